// File: rtl/s_inter_pkg.sv
// Shared definitions for the inbound response path: packet type codes,
// header field positions and the receive FSM state encoding.
package s_inter_pkg;

  localparam logic [3:0] TYPE_R = 4'b0011;
  localparam logic [3:0] TYPE_B = 4'b0100;

  localparam int HDR_TYPE_LSB = 0;
  localparam int HDR_TYPE_MSB = 3;
  localparam int HDR_RESP_LSB = 4;
  localparam int HDR_RESP_MSB = 5;
  localparam int HDR_ID_LSB   = 6;
  localparam int HDR_ID_MSB   = 23;
  localparam int HDR_LEN_LSB  = 24;
  localparam int HDR_LEN_MSB  = 31;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_R_DATA = 2'd1,
    ST_DROP   = 2'd2
  } state_e;

endpackage

// File: rtl/s_inter_out_slice.sv
// One-entry valid/ready output register; payload is captured on an input
// handshake and held until the downstream accepts it.
module s_inter_out_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign in_ready  = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Holding register: load on input handshake, release on output handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (in_valid && in_ready) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/s_inter_rx.sv
// Inbound response depacketiser: decodes header beats, rebuilds full AXI IDs
// from the connection ID and emits AXI R/B responses; malformed packets are counted.
module s_inter_rx
  import s_inter_pkg::*;
#(
  parameter int ID_W  = 22,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [127:0]     rx_data,
  input  logic [15:0]      rx_keep,
  input  logic             rx_last,
  input  logic [3:0]       rx_connection_id,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [127:0]     s_axi_rdata,
  output logic [ID_W-1:0]  s_axi_rid,
  output logic [1:0]       s_axi_rresp,
  output logic             s_axi_rlast,
  output logic             s_axi_rvalid,
  input  logic             s_axi_rready,
  output logic [ID_W-1:0]  s_axi_bid,
  output logic [1:0]       s_axi_bresp,
  output logic             s_axi_bvalid,
  input  logic             s_axi_bready,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int R_W = 128 + ID_W + 2 + 1;
  localparam int B_W = ID_W + 2;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e            state_r, state_s;
  logic [7:0]        cnt_r, cnt_s;
  logic [7:0]        len_r, len_s;
  logic [ID_W-1:0]   rid_r, rid_s;
  logic [1:0]        rresp_r, rresp_s;
  logic [ERR_W-1:0]  err_r;
  logic              live_r;
  logic              err_inc_s, r_load_s, b_load_s, r_last_s;
  logic [1:0]        r_out_resp_s;
  logic              rx_ready_s, accept_s;
  logic              r_in_ready_s, b_ready_unused_s, keep_unused_s;
  logic [R_W-1:0]    r_out_data_s;
  logic [B_W-1:0]    b_out_data_s;

  logic [3:0]        hdr_type_s;
  logic [1:0]        hdr_resp_s;
  logic [7:0]        hdr_len_s;
  logic [ID_W-1:0]   hdr_id_s;

  assign hdr_type_s    = rx_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
  assign hdr_resp_s    = rx_data[HDR_RESP_MSB:HDR_RESP_LSB];
  assign hdr_len_s     = rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_id_s      = {rx_connection_id, rx_data[HDR_ID_LSB +: ID_W-4]};
  assign keep_unused_s = ^rx_keep;

  assign rx_ready = rx_ready_s;
  assign accept_s = rx_valid & rx_ready_s;
  assign err_cnt  = err_r;

  // Ingress ready; a pending B response also holds off R headers in IDLE.
  always_comb begin
    rx_ready_s = 1'b0;
    if (live_r) begin
      case (state_r)
        ST_IDLE:   rx_ready_s = ~s_axi_bvalid;
        ST_R_DATA: rx_ready_s = r_in_ready_s;
        ST_DROP:   rx_ready_s = 1'b1;
        default:   rx_ready_s = 1'b0;
      endcase
    end else begin
      rx_ready_s = 1'b0;
    end
  end

  // Packet decode: next state, latched R context and output loads.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    len_s        = len_r;
    rid_s        = rid_r;
    rresp_s      = rresp_r;
    err_inc_s    = 1'b0;
    r_load_s     = 1'b0;
    b_load_s     = 1'b0;
    r_last_s     = 1'b0;
    r_out_resp_s = rresp_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (hdr_type_s)
            TYPE_B: begin
              if (rx_last) begin
                b_load_s = 1'b1;
              end else begin
                err_inc_s = 1'b1;
                state_s   = ST_DROP;
              end
            end
            TYPE_R: begin
              if (!rx_last) begin
                rid_s   = hdr_id_s;
                rresp_s = hdr_resp_s;
                len_s   = hdr_len_s;
                cnt_s   = 8'd0;
                state_s = ST_R_DATA;
              end else begin
                err_inc_s = 1'b1;
              end
            end
            default: begin
              err_inc_s = 1'b1;
              if (rx_last) begin
                state_s = ST_IDLE;
              end else begin
                state_s = ST_DROP;
              end
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_R_DATA: begin
        if (accept_s) begin
          r_load_s = 1'b1;
          if (cnt_r == len_r) begin
            r_last_s = 1'b1;
            if (rx_last) begin
              state_s = ST_IDLE;
            end else begin
              err_inc_s = 1'b1;
              state_s   = ST_DROP;
            end
          end else if (rx_last) begin
            // Truncated burst: close it out towards AXI with an error beat.
            r_last_s     = 1'b1;
            r_out_resp_s = RESP_SLVERR;
            err_inc_s    = 1'b1;
            state_s      = ST_IDLE;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end else begin
          state_s = ST_R_DATA;
        end
      end
      ST_DROP: begin
        if (accept_s && rx_last) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state and R burst context.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      len_r   <= 8'd0;
      rid_r   <= '0;
      rresp_r <= 2'b00;
      live_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
      rid_r   <= rid_s;
      rresp_r <= rresp_s;
      live_r  <= 1'b1;
    end
  end

  // Saturating malformed-packet counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_r <= '0;
    end else if (err_inc_s) begin
      err_r <= sat_inc(err_r);
    end else begin
      err_r <= err_r;
    end
  end

  s_inter_out_slice #(.W(R_W)) u_r_slice (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (r_load_s),
    .in_ready  (r_in_ready_s),
    .in_data   ({rx_data, rid_r, r_out_resp_s, r_last_s}),
    .out_valid (s_axi_rvalid),
    .out_ready (s_axi_rready),
    .out_data  (r_out_data_s)
  );

  s_inter_out_slice #(.W(B_W)) u_b_slice (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (b_load_s),
    .in_ready  (b_ready_unused_s),
    .in_data   ({hdr_id_s, hdr_resp_s}),
    .out_valid (s_axi_bvalid),
    .out_ready (s_axi_bready),
    .out_data  (b_out_data_s)
  );

  assign {s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast} = r_out_data_s;
  assign {s_axi_bid, s_axi_bresp} = b_out_data_s;

endmodule

// File: tb/tb_s_inter_rx.sv
// Self-checking bench for s_inter_rx: B vectors from a table, R bursts and
// corner cases from short sequences, outputs checked against scoreboard queues.
module tb_s_inter_rx;

  logic         clk;
  logic         resetn;
  logic [127:0] rx_data;
  logic [15:0]  rx_keep;
  logic         rx_last;
  logic [3:0]   rx_connection_id;
  logic         rx_valid;
  logic         rx_ready;
  logic [127:0] s_axi_rdata;
  logic [21:0]  s_axi_rid;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic [21:0]  s_axi_bid;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [15:0]  err_cnt;

  s_inter_rx dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_keep(rx_keep),
    .rx_last(rx_last), .rx_connection_id(rx_connection_id),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [127:0] data;
    logic [21:0]  id;
    logic [1:0]   resp;
    logic         last;
  } r_exp_t;

  typedef struct {
    logic [21:0] id;
    logic [1:0]  resp;
  } b_exp_t;

  typedef struct {
    logic [1:0]  resp;
    logic [17:0] id;
    logic [3:0]  conn;
    logic [21:0] exp_bid;
    logic [1:0]  exp_bresp;
  } b_vec_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];
  int     errors = 0;
  int     checks = 0;
  int     exp_err = 0;
  logic   bp_chk = 1'b0;
  logic   rr_mode = 1'b0;
  logic   prev_stall = 1'b0;
  logic [152:0] prev_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_axi_rready driver: held high, or the 1,0,0,1 pattern in backpressure mode
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    s_axi_rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode) begin
        s_axi_rready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        s_axi_rready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pops, stall stability, ingress hold-off
  always @(negedge clk) begin
    r_exp_t re;
    b_exp_t be;
    logic [152:0] cur;
    cur = {s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast};
    if (resetn && s_axi_rvalid && s_axi_rready) begin
      checks++;
      if (r_q.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected got rid=%h rdata=%h", s_axi_rid, s_axi_rdata);
      end else begin
        re = r_q.pop_front();
        if (cur !== {re.data, re.id, re.resp, re.last}) begin
          errors++;
          $display("FAIL r_beat got data=%h id=%h resp=%b last=%b exp data=%h id=%h resp=%b last=%b",
                   s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, re.data, re.id, re.resp, re.last);
        end
      end
    end
    if (resetn && s_axi_bvalid && s_axi_bready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected got bid=%h", s_axi_bid);
      end else begin
        be = b_q.pop_front();
        if ({s_axi_bid, s_axi_bresp} !== {be.id, be.resp}) begin
          errors++;
          $display("FAIL b_resp got bid=%h bresp=%b exp bid=%h bresp=%b",
                   s_axi_bid, s_axi_bresp, be.id, be.resp);
        end
      end
    end
    if (prev_stall) begin
      checks++;
      if (!s_axi_rvalid || cur !== prev_r) begin
        errors++;
        $display("FAIL r_stall_hold got valid=%b r=%h exp valid=1 r=%h", s_axi_rvalid, cur, prev_r);
      end
    end
    if (bp_chk && s_axi_rvalid && !s_axi_rready) begin
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL rx_ready_holdoff got %b exp 0", rx_ready);
      end
    end
    prev_stall = resetn && s_axi_rvalid && !s_axi_rready;
    prev_r = cur;
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] hdr(input logic [3:0] t, input logic [1:0] r,
                                       input logic [17:0] id, input logic [7:0] len);
    hdr = {96'hFACE_0000_0000_0000_0000_0000, len, id, r, t};
  endfunction

  task automatic send_beat(input logic [127:0] d, input logic last, input logic [3:0] conn);
    logic ok;
    ok = 1'b0;
    rx_data = d;
    rx_last = last;
    rx_connection_id = conn;
    rx_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ok = rx_ready;
      @(posedge clk);
      #2;
      if (ok) break;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout got rx_ready=0 exp 1 within 300 cycles");
    end
  endtask

  task automatic send_b(input logic [1:0] resp, input logic [17:0] id, input logic [3:0] conn,
                        input logic [21:0] exp_id);
    b_q.push_back('{id: exp_id, resp: resp});
    send_beat(hdr(4'b0100, resp, id, 8'd0), 1'b1, conn);
  endtask

  // R packet with nbeats data beats; expectations follow the packet rules
  task automatic send_r(input logic [7:0] len, input logic [17:0] id, input logic [3:0] conn,
                        input logic [1:0] resp, input int nbeats, input logic bp);
    logic [127:0] d;
    send_beat(hdr(4'b0011, resp, id, len), nbeats == 0, conn);
    if (nbeats == 0 || nbeats - 1 != int'(len)) exp_err++;
    bp_chk = bp;
    for (int i = 0; i < nbeats; i++) begin
      d = {32'(i), 32'hC0DE_0000 ^ 32'(len), 32'(id), 32'hFFFF_FFFF - 32'(i)};
      if (i <= int'(len))
        r_q.push_back('{data: d, id: {conn, id},
                        resp: (i == nbeats - 1 && i < int'(len)) ? 2'b10 : resp,
                        last: (i == int'(len)) || (i == nbeats - 1)});
      send_beat(d, i == nbeats - 1, conn);
    end
    bp_chk = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400; n++) begin
      if (r_q.size() == 0 && b_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    chk("drain_pending", 128'(r_q.size() + b_q.size()), 128'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b_vec_t bt[4];
    bt[0] = '{resp: 2'b00, id: 18'h1ABCD, conn: 4'h5, exp_bid: 22'h15ABCD, exp_bresp: 2'b00};
    bt[1] = '{resp: 2'b01, id: 18'h00001, conn: 4'hA, exp_bid: 22'h280001, exp_bresp: 2'b01};
    bt[2] = '{resp: 2'b11, id: 18'h3FFFF, conn: 4'hF, exp_bid: 22'h3FFFFF, exp_bresp: 2'b11};
    bt[3] = '{resp: 2'b10, id: 18'h00000, conn: 4'h0, exp_bid: 22'h000000, exp_bresp: 2'b10};

    resetn = 1'b0;
    rx_data = 128'd0;
    rx_keep = 16'hFFFF;
    rx_last = 1'b0;
    rx_connection_id = 4'h0;
    rx_valid = 1'b0;
    s_axi_bready = 1'b1;
    #12;
    chk("reset_rx_ready", 128'(rx_ready), 128'd0);
    chk("reset_rvalid", 128'(s_axi_rvalid), 128'd0);
    chk("reset_bvalid", 128'(s_axi_bvalid), 128'd0);
    chk("reset_err_cnt", 128'(err_cnt), 128'd0);
    chk("reset_r_fields", 128'({s_axi_rdata[31:0], s_axi_rid, s_axi_rresp, s_axi_rlast}), 128'd0);
    chk("reset_b_fields", 128'({s_axi_bid, s_axi_bresp}), 128'd0);
    #10;
    resetn = 1'b1;
    @(posedge clk);
    #2;
    chk("rx_ready_after_reset", 128'(rx_ready), 128'd1);

    // B packets from the table; first one also checks one-cycle latency
    for (int k = 0; k < 4; k++) begin
      send_b(bt[k].resp, bt[k].id, bt[k].conn, bt[k].exp_bid);
      chk("b_latency_valid", 128'(s_axi_bvalid), 128'd1);
      chk("b_latency_fields", 128'({s_axi_bid, s_axi_bresp}), 128'({bt[k].exp_bid, bt[k].exp_bresp}));
    end
    drain();

    // Plain 4-beat burst
    send_r(8'd3, 18'h00042, 4'h2, 2'b00, 4, 1'b0);
    drain();
    chk("err_after_normal_r", 128'(err_cnt), 128'd0);

    // Backpressure on an 8-beat burst
    rr_mode = 1'b1;
    send_r(8'd7, 18'h2A5A5, 4'h9, 2'b01, 8, 1'b1);
    drain();
    rr_mode = 1'b0;
    @(posedge clk);
    #2;

    // Early rx_last, then a normal single-beat burst
    send_r(8'd5, 18'h01234, 4'h3, 2'b00, 2, 1'b0);
    send_r(8'd0, 18'h00777, 4'h4, 2'b11, 1, 1'b0);
    drain();
    chk("err_after_early_last", 128'(err_cnt), 128'(exp_err));

    // Overlong R, unknown types, R header with no data, multi-beat B
    send_r(8'd1, 18'h3C3C3, 4'h6, 2'b00, 4, 1'b0);
    send_beat(hdr(4'hF, 2'b00, 18'h11111, 8'd0), 1'b0, 4'h1);
    send_beat(128'h1, 1'b0, 4'h1);
    send_beat(128'h2, 1'b1, 4'h1);
    exp_err++;
    send_beat(hdr(4'h0, 2'b00, 18'h22222, 8'd0), 1'b1, 4'h1);
    exp_err++;
    send_r(8'd2, 18'h00055, 4'h7, 2'b00, 0, 1'b0);
    send_beat(hdr(4'b0100, 2'b00, 18'h33333, 8'd0), 1'b0, 4'h8);
    send_beat(128'h3, 1'b1, 4'h8);
    exp_err++;
    send_b(2'b01, 18'h00ABC, 4'hC, 22'h300ABC);
    drain();
    chk("err_after_malformed", 128'(err_cnt), 128'(exp_err));

    // Reset during beat 2 of a len=7 burst
    r_q.push_back('{data: 128'hAAAA_0000, id: {4'hD, 18'h0BEEF}, resp: 2'b00, last: 1'b0});
    send_beat(hdr(4'b0011, 2'b00, 18'h0BEEF, 8'd7), 1'b0, 4'hD);
    send_beat(128'hAAAA_0000, 1'b0, 4'hD);
    send_beat(128'hAAAA_0001, 1'b0, 4'hD);
    rx_data = 128'hAAAA_0002;
    rx_valid = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    chk("midreset_rvalid", 128'(s_axi_rvalid), 128'd0);
    chk("midreset_err_cnt", 128'(err_cnt), 128'd0);
    chk("midreset_rx_ready", 128'(rx_ready), 128'd0);
    exp_err = 0;
    rx_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #2;
    send_b(2'b00, 18'h1ABCD, 4'h5, 22'h15ABCD);
    chk("post_reset_b_valid", 128'(s_axi_bvalid), 128'd1);
    drain();
    chk("err_final", 128'(err_cnt), 128'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s_inter_rx.md
# s_inter_rx

Receive-side transaction-layer block that turns inbound response packets back into AXI R and B responses for the local slave port. It is the remote counterpart of the master-side response packer: it consumes one 128-bit packet stream, decodes the header beat, and reconstructs full 22-bit AXI IDs by prepending the packet's 4-bit connection ID. Malformed packets are discarded and counted.

## Interface
Parameters:
- ID_W, 22, full AXI ID width; the upper 4 bits are the connection ID.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  block clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- rx_data  in  128  packet beat.
- rx_keep  in  16  byte enables; informational, not checked.
- rx_last  in  1  last beat of packet.
- rx_connection_id  in  4  connection ID, valid on the header beat.
- rx_valid / rx_ready  in / out  1 / 1  ingress handshake.
- s_axi_rdata  out  128  read data.
- s_axi_rid  out  ID_W  {connection ID, header id[17:0]}.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid / s_axi_rready  out / in  1 / 1  R handshake.
- s_axi_bid  out  ID_W  write-response ID.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1 / 1  B handshake.
- err_cnt  out  ERR_W  count of malformed packets; saturates at all-ones.

## Operation
Header beat (first beat of every packet) fields:
- [3:0]: type.
- [5:4]: resp.
- [23:6]: id[17:0].
- [31:24]: len, meaning R beats minus 1. Meaningful for R packets only.

Type codes:
- 4'b0011: R packet. The header beat is followed by len+1 data beats.
- 4'b0100: B packet. Exactly one beat, so rx_last=1 on the header.
- Any other value: unknown.

FSM states: IDLE, R_DATA, DROP.
- IDLE, B header with rx_last=1: load the B output register; stay in IDLE.
- IDLE, B header with rx_last=0: err_cnt+1; go to DROP.
- IDLE, R header with rx_last=0: latch id, resp and len; clear the beat counter; go to R_DATA.
- IDLE, R header with rx_last=1 (no data): err_cnt+1; stay in IDLE; emit nothing.
- IDLE, unknown type: err_cnt+1; go to DROP, or stay in IDLE if rx_last=1.
- R_DATA: each accepted beat loads the R output register with the latched id and resp. rlast=1 when the counter equals len or when rx_last=1.
- R_DATA, early rx_last (counter < len): rlast=1, rresp forced to 2'b10 (SLVERR) on that beat, err_cnt+1, go to IDLE.
- R_DATA, counter == len with rx_last=0: emit that beat with rlast=1, err_cnt+1, go to DROP.
- R_DATA, counter == len with rx_last=1: normal completion; go to IDLE.
- DROP: rx_ready=1; discard beats; go to IDLE on an accepted rx_last.
- The beat counter is 8 bits; len=255 means 256 beats, with no wrap inside a packet.

## Timing
- rx_ready:
  - IDLE: ~bvalid_q. R headers are also held off while a B response is pending.
  - R_DATA: ~rvalid_q | s_axi_rready.
  - DROP: 1.
- Latency: a beat accepted at cycle N appears on s_axi_r*/s_axi_b* at N+1. Full throughput of one beat per cycle while the downstream is ready.
- Output registers hold stable while valid && !ready. valid deasserts only after a handshake. AXI R and B ordering follows packet arrival order.
- Reset values: rx_ready=0, s_axi_rvalid=0, s_axi_bvalid=0, all data/id/resp/last outputs 0, err_cnt=0, state=IDLE. rx_ready is low during reset and rises on the first cycle after resetn deasserts.
- Reset asserted mid-packet: state, counter and both output registers clear immediately. Any in-flight response is lost. The next ingress beat is treated as a header.

## Structure
- Package s_inter_pkg holds:
  - Type codes TYPE_R=4'b0011 and TYPE_B=4'b0100.
  - Header field bit positions.
  - RESP_SLVERR=2'b10.
  - The FSM state enum.
- Sub-module s_inter_out_slice: a one-entry valid/ready register slice, parameterised by payload width. It is instantiated twice: R payload = 128+22+2+1 bits, B payload = 22+2 bits.

## Test plan
- B packet: header type 0100, resp 00, id 18'h1ABCD, rx_connection_id 4'h5, rx_last=1 -> next cycle s_axi_bvalid=1, bid=22'h15ABCD, bresp=00.
- R packet: len=3, id 18'h00042, conn 4'h2, 4 data beats 0..3, rready held high -> 4 consecutive R beats with rid=22'h080042 and rlast only on beat 3; err_cnt stays 0.
- Backpressure: R packet of len=7 with s_axi_rready toggling 1,0,0,1 -> no beat lost or duplicated, rdata stable while stalled, rx_ready low whenever rvalid=1 && !rready.
- Early rx_last: len=5 with rx_last on the 2nd data beat -> 2 beats out, the 2nd with rlast=1 and rresp=10, err_cnt=1, next packet decoded normally.
- Overlong and unknown packets: a len=1 R packet with 4 data beats -> 2 beats out, 2 beats dropped, err_cnt+1. A type 4'hF packet of 3 beats -> no output, err_cnt+1.
- Reset mid-burst: drop resetn during beat 2 of a len=7 packet -> rvalid=0 and err_cnt=0 immediately; after release, a B packet is decoded correctly.
